// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a DEPTH x 32 word memory with byte-lane writes.
// Latency: termination (ACK/ERR/RTY) is registered, high one cycle after edge k+WAIT_STATES.
// Backpressure: master holds CYC/STB until termination; dropping them during wait states aborts.
module wb_slave_mem #(
    parameter int unsigned AW          = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RTY_PERIOD  = 0
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [AW-1:0] ADR_I,
    input  logic [31:0]   DAT_I,
    input  logic [3:0]    SEL_I,
    input  logic          WE_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    output logic [31:0]   DAT_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          RTY_O
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] TERM = 2'd2;
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [31:0]   rty_cnt;
    logic [AW-3:0] adr_q;
    logic          we_q;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          enter_term;
    logic          in_range;
    logic          rty_hit;
    logic          wr_en;
    logic [AW-3:0] cur_word;
    logic          cur_we;
    logic [31:0]   cur_idx;
    logic [IW-1:0] mem_idx;

    // Byte offset bits carry no meaning for a word-wide memory.
    logic unused_adr_bits;
    assign unused_adr_bits = ^ADR_I[1:0];

    assign req = CYC_I & STB_I;

    // Address/direction come straight from the bus when terminating from IDLE, else from the latch.
    always_comb begin
        cur_word   = (state == IDLE) ? ADR_I[AW-1:2] : adr_q;
        cur_we     = (state == IDLE) ? WE_I : we_q;
        cur_idx    = 32'(cur_word);
        mem_idx    = cur_idx[IW-1:0];
        in_range   = (cur_idx < DEPTH);
        rty_hit    = in_range && (RTY_PERIOD != 0) && ((rty_cnt + 32'd1) == RTY_PERIOD);
        enter_term = 1'b0;
        if (req) begin
            if (state == IDLE) begin
                enter_term = (WAIT_STATES == 0);
            end else if (state == WAIT) begin
                enter_term = (wait_cnt == 4'd1);
            end
        end
        // A reset landing on the terminating edge must not commit the write.
        wr_en = enter_term && in_range && !rty_hit && cur_we && !RST_I;
    end

    // Access sequencing, termination outputs, read data and retry counting.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            rty_cnt  <= 32'd0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            DAT_O    <= 32'h0;
            ACK_O    <= 1'b0;
            ERR_O    <= 1'b0;
            RTY_O    <= 1'b0;
        end else begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            RTY_O <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        adr_q    <= ADR_I[AW-1:2];
                        we_q     <= WE_I;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? TERM : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state <= TERM;
                        end
                    end
                end
                TERM:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_term) begin
                if (!in_range) begin
                    ERR_O <= 1'b1;
                    DAT_O <= 32'h0;
                end else if (rty_hit) begin
                    RTY_O   <= 1'b1;
                    DAT_O   <= 32'h0;
                    rty_cnt <= 32'd0;
                end else begin
                    ACK_O <= 1'b1;
                    DAT_O <= cur_we ? 32'h0 : mem[mem_idx];
                    if (RTY_PERIOD != 0) begin
                        rty_cnt <= rty_cnt + 32'd1;
                    end
                end
            end
        end
    end

    // Byte-lane write on the edge entering TERM; contents survive reset.
    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (SEL_I[b]) begin
                    mem[mem_idx][8*b +: 8] <= DAT_I[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter AW, 16, address width of ADR_I (byte address).
REQ-002 Parameter DEPTH, 1024, number of 32-bit words implemented.
REQ-003 Parameter WAIT_STATES, 0, extra cycles inserted before each termination (0-15).
REQ-004 Parameter RTY_PERIOD, 0, every RTY_PERIOD-th in-range access is terminated with RTY_O; 0 disables retry.
REQ-005 CLK_I  in  1  clock; all state changes on the rising edge.
REQ-006 RST_I  in  1  reset, asynchronous, active-high.
REQ-007 ADR_I  in  AW  byte address; word index = ADR_I[AW-1:2], ADR_I[1:0] ignored.
REQ-008 DAT_I  in  32  write data.
REQ-009 SEL_I  in  4  byte lane enables; bit n covers DAT_I[8n+7:8n].
REQ-010 WE_I  in  1  1 = write, 0 = read.
REQ-011 CYC_I  in  1  bus cycle in progress.
REQ-012 STB_I  in  1  strobe; a request is CYC_I & STB_I.
REQ-013 DAT_O  out  32  read data, registered.
REQ-014 ACK_O  out  1  normal termination, registered.
REQ-015 ERR_O  out  1  error termination, registered.
REQ-016 RTY_O  out  1  retry termination, registered.

Function
REQ-017 Storage is DEPTH x 32 bits; word index >= DEPTH is out of range.
REQ-018 FSM states: IDLE, WAIT, TERM.
REQ-019 IDLE: at the edge sampling a request, load the wait counter with WAIT_STATES; go to TERM if WAIT_STATES = 0, else WAIT.
REQ-020 WAIT: decrement the counter each edge; go to TERM at the edge where the counter reads 1.
REQ-021 TERM: exactly one of ACK_O/ERR_O/RTY_O is high for exactly one cycle; the next edge returns to IDLE with all three low.
REQ-022 Latency: a request first sampled at edge k raises the termination output after edge k+WAIT_STATES.
REQ-023 Request still asserted at the edge leaving TERM is not treated as a new request; the earliest next request is sampled one edge after returning to IDLE.
REQ-024 Termination priority: ERR (out of range) > RTY (retry count hit) > ACK.
REQ-025 Retry counter: increments once per in-range termination (ACK or RTY); when it reaches RTY_PERIOD, that termination is RTY and the counter clears to 0.
REQ-026 Out-of-range accesses do not touch the retry counter.
REQ-027 Write with ACK: on the edge entering TERM, update only byte lanes with SEL_I bit set; other lanes unchanged.
REQ-028 ERR or RTY termination: no memory write.
REQ-029 Read with ACK: DAT_O holds mem[index] during the ACK cycle.
REQ-030 Read with ERR/RTY, and all writes: DAT_O is 32'h0 during the termination cycle.
REQ-031 DAT_O holds its value outside termination cycles.
REQ-032 Abort: CYC_I or STB_I low at any edge in WAIT returns to IDLE with no termination, no write and no retry-counter change.
REQ-033 Inputs are sampled at the edge entering TERM (write data/SEL_I) and at the edge leaving IDLE (ADR_I, WE_I); the master holds them stable throughout.

Reset
REQ-034 RST_I high asynchronously forces IDLE, ACK_O=ERR_O=RTY_O=0, DAT_O=32'h0, wait counter=0 and retry counter=0.
REQ-035 Reset mid-access (WAIT or TERM) drops any pending termination and performs no write.
REQ-036 Memory contents are not cleared by reset; the bench initialises them.
REQ-037 First request is sampled no earlier than the first rising edge after RST_I deasserts.

Verification
REQ-038 WAIT_STATES=0: write 32'hDEADBEEF, SEL=4'hF to 0x0010, then read 0x0010 -> ACK_O one cycle after STB_I each time; read returns 32'hDEADBEEF.
REQ-039 Byte lanes: mem[4]=32'h11223344, write 32'hAABBCCDD SEL=4'b0101 to 0x0010 -> read returns 32'h11BB33DD.
REQ-040 WAIT_STATES=3: read 0x0000 -> ACK_O rises after edge k+3, high one cycle; ERR_O/RTY_O stay 0.
REQ-041 DEPTH=1024: write to 0x1000 -> ERR_O one cycle, mem unchanged; a subsequent read of word 0 returns its prior value.
REQ-042 RTY_PERIOD=3: six in-range reads back to back -> terminations ACK,ACK,RTY,ACK,ACK,RTY; RTY reads give DAT_O=0.
REQ-043 WAIT_STATES=4: drop STB_I two cycles into a write; separately, pulse RST_I in WAIT -> no termination, no memory change, next access completes normally.
